// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Buffers ALU commands in a small FIFO and feeds them one at a time to an
//   external combinational 4-bit ALU. Each command spends one cycle in ISSUE,
//   where the ALU response is captured. It then waits in HOLD until the
//   downstream consumer takes the response.
//
// Parameters
//   DEPTH       command FIFO entries (power of two, 2..16)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   command handshake (in_ready = FIFO not full)
//   in_op, in_a, in_b   opcode (000 add, 001 sub, 010 and, 011 or, 100 xor)
//                       and operands
//   alu_a/alu_b/alu_op  registered operands/opcode driven to the ALU
//   alu_result, alu_cout, alu_zero   combinational ALU response
//   out_valid/out_ready response handshake
//   out_result, out_cout, out_zero   captured response
//   count               commands currently held in the FIFO
//   err_op              sticky illegal-opcode flag
//
// Build option
//   ALU_OPCHECK_EN  when defined, opcodes 101..111 bypass the ALU.
//                   They produce result 0, cout 0 and zero 1, and they set
//                   err_op until reset. When undefined, every opcode goes to
//                   the ALU unchanged and err_op is tied low.
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [3:0]               in_a,
   input  logic [3:0]               in_b,
   output logic [3:0]               alu_a,
   output logic [3:0]               alu_b,
   output logic [2:0]               alu_op,
   input  logic [3:0]               alu_result,
   input  logic                     alu_cout,
   input  logic                     alu_zero,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_result,
   output logic                     out_cout,
   output logic                     out_zero,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_op
);

   localparam int DATA_W = 4;
   localparam int OP_W   = 3;
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = PW + 1;
   localparam int ENT_W  = OP_W + 2 * DATA_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t              state_q, state_d;
   logic [ENT_W-1:0]    mem [DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count_q;
   logic                push, pop, capture, handshake, fifo_empty;
   logic [OP_W-1:0]     head_op;
   logic [DATA_W-1:0]   head_a, head_b;
   logic [DATA_W-1:0]   cap_result;
   logic                cap_cout, cap_zero;

   assign fifo_empty = (count_q == '0);
   // Fullness alone gates acceptance; a same-cycle pop does not free a slot.
   assign in_ready   = (count_q != FULL_CNT);
   assign push       = in_valid && in_ready;
   assign handshake  = out_valid && out_ready;
   assign count      = count_q;
   assign {head_op, head_a, head_b} = mem[rd_ptr];

   // ---- FIFO storage: data only, not cleared by reset ----
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_op, in_a, in_b};
      end
   end

   // ---- Sequencer next-state / control ----
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            capture = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (handshake) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ALU_OPCHECK_EN
   logic op_bad_q;
   logic err_op_q;

   // Legality of the command now sitting in the alu_* registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_bad_q <= 1'b0;
         err_op_q <= 1'b0;
      end else begin
         if (pop) begin
            op_bad_q <= (head_op > 3'd4);
         end
         if (capture && op_bad_q) begin
            err_op_q <= 1'b1;
         end
      end
   end

   assign cap_result = op_bad_q ? '0 : alu_result;
   assign cap_cout   = op_bad_q ? 1'b0 : alu_cout;
   assign cap_zero   = op_bad_q ? 1'b1 : alu_zero;
   assign err_op     = err_op_q;
`else
   assign cap_result = alu_result;
   assign cap_cout   = alu_cout;
   assign cap_zero   = alu_zero;
   assign err_op     = 1'b0;
`endif

   // ---- State, pointers, ALU operand and response registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_cout   <= 1'b0;
         out_zero   <= 1'b0;
      end else begin
         state_q <= state_d;

         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            alu_a  <= head_a;
            alu_b  <= head_b;
            alu_op <= head_op;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase

         if (capture) begin
            out_valid  <= 1'b1;
            out_result <= cap_result;
            out_cout   <= cap_cout;
            out_zero   <= cap_zero;
         end else if (handshake) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule
